// File: rtl/maze_pkg.sv
// Shared constants and helpers for the maze pixel renderer: grid geometry,
// palette and the stage-1 pipeline record.
package maze_pkg;

  localparam int GRID_W     = 40;
  localparam int GRID_H     = 30;
  localparam int CELL_SHIFT = 4;
  localparam int ADDR_W     = 11;
  localparam int H_VIS      = GRID_W << CELL_SHIFT;
  localparam int V_VIS      = GRID_H << CELL_SHIFT;

  localparam logic [11:0] BLACK  = 12'h000;
  localparam logic [11:0] PLAYER = 12'hF80;
  localparam logic [11:0] GOAL   = 12'h0F0;
  localparam logic [11:0] WALL   = 12'h00F;
  localparam logic [11:0] FLOOR  = 12'hFFF;
  localparam logic [11:0] WIN    = 12'hFF0;

  typedef struct packed {
    logic visible;
    logic hsync;
    logic vsync;
    logic is_player;
    logic is_goal;
    logic inner;
  } stage1_t;

  // Syncs idle high so the delayed sync outputs stay inactive out of reset.
  localparam stage1_t STAGE1_RST = '{visible: 1'b0, hsync: 1'b1, vsync: 1'b1,
                                     is_player: 1'b0, is_goal: 1'b0, inner: 1'b0};

  // row*40 + col built from shifts so no multiplier is inferred.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] row, input logic [5:0] col);
    logic [ADDR_W-1:0] r_ext;
    r_ext = {6'b0, row};
    return (r_ext << 5) + (r_ext << 3) + {5'b0, col};
  endfunction

  // Offsets 2..13 leave a 2-pixel border so sprites read as inset squares.
  function automatic logic cell_inner(input logic [CELL_SHIFT-1:0] off);
    return (off >= 4'd2) && (off <= 4'd13);
  endfunction

endpackage

// File: rtl/frame_blink_counter.sv
// Frame-start detector (vsync falling edge sampled at pix_en), frame tick,
// win-flash frame counter/phase and the shadow-latch strobe.
module frame_blink_counter #(
  parameter int BLINK_FRAMES = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pix_en,
  input  logic i_vsync,
  input  logic i_game_won,
  output logic o_frame_tick,
  output logic o_blink_phase,
  output logic o_latch_en
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic             r_vs_prev;
  logic             r_frame_tick;
  logic             r_blink_phase;
  logic [CNT_W-1:0] r_blink_count;
  logic             w_fall;

  // pix_en is never high on back-to-back clocks, so the tick is one clk wide.
  assign w_fall = i_pix_en && r_vs_prev && !i_vsync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vs_prev     <= 1'b1;
      r_frame_tick  <= 1'b0;
      r_blink_phase <= 1'b0;
      r_blink_count <= '0;
    end else begin
      r_frame_tick <= w_fall;
      if (i_pix_en) begin
        r_vs_prev <= i_vsync;
      end
      if (!i_game_won) begin
        r_blink_phase <= 1'b0;
        r_blink_count <= '0;
      end else if (w_fall) begin
        if (r_blink_count == CNT_LAST) begin
          r_blink_count <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_blink_count <= r_blink_count + CNT_W'(1);
        end
      end
    end
  end

  assign o_frame_tick  = r_frame_tick;
  assign o_blink_phase = r_blink_phase;
  assign o_latch_en    = w_fall;

endmodule

// File: rtl/maze_pixel_renderer.sv
// Two-stage pixel pipeline: stage 1 issues the wall RAM address and cell flags,
// stage 2 picks the colour once the RAM bit is back. Syncs travel alongside.
module maze_pixel_renderer
  import maze_pkg::*;
#(
  parameter int BLINK_FRAMES = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_en,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  input  logic              video_on,
  input  logic              hsync_in,
  input  logic              vsync_in,
  output logic [ADDR_W-1:0] maze_addr,
  input  logic              maze_data,
  input  logic [5:0]        player_col,
  input  logic [4:0]        player_row,
  input  logic [5:0]        goal_col,
  input  logic [4:0]        goal_row,
  input  logic              game_won,
  output logic [11:0]       rgb,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              frame_tick
);

  // Handshake: pix_en is a one-clk qualifier from the VGA controller; every
  // pipeline register loads only when it is high and holds otherwise, and the
  // result for a coordinate is on rgb after the second following pix_en.
  logic [5:0]        w_col;
  logic [5:0]        w_row;
  logic              w_in_range;
  logic              w_inner;
  logic              w_is_player;
  logic              w_is_goal;
  logic [ADDR_W-1:0] w_addr;
  logic              w_latch_en;
  logic              w_blink_phase;
  logic [11:0]       w_rgb;

  logic [ADDR_W-1:0] r_maze_addr;
  stage1_t           r_s1;
  logic [5:0]        r_player_col;
  logic [4:0]        r_player_row;
  logic [5:0]        r_goal_col;
  logic [4:0]        r_goal_row;
  logic [11:0]       r_rgb;
  logic              r_hsync_out;
  logic              r_vsync_out;

  frame_blink_counter #(
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_frame_blink (
    .clk           (clk),
    .reset         (reset),
    .i_pix_en      (pix_en),
    .i_vsync       (vsync_in),
    .i_game_won    (game_won),
    .o_frame_tick  (frame_tick),
    .o_blink_phase (w_blink_phase),
    .o_latch_en    (w_latch_en)
  );

  assign w_col       = hcount[9:CELL_SHIFT];
  assign w_row       = vcount[9:CELL_SHIFT];
  assign w_in_range  = (hcount < 10'(H_VIS)) && (vcount < 10'(V_VIS));
  assign w_addr      = w_in_range ? cell_addr(w_row[4:0], w_col) : '0;
  assign w_inner     = cell_inner(hcount[CELL_SHIFT-1:0]) && cell_inner(vcount[CELL_SHIFT-1:0]);
  assign w_is_player = (w_col == r_player_col) && (w_row == {1'b0, r_player_row});
  assign w_is_goal   = (w_col == r_goal_col) && (w_row == {1'b0, r_goal_row});

  // Stage 1 plus the per-frame shadow copies of player/goal.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_maze_addr  <= '0;
      r_s1         <= STAGE1_RST;
      r_player_col <= '0;
      r_player_row <= '0;
      r_goal_col   <= '0;
      r_goal_row   <= '0;
    end else begin
      if (pix_en) begin
        r_maze_addr     <= w_addr;
        r_s1.visible    <= video_on && w_in_range;
        r_s1.hsync      <= hsync_in;
        r_s1.vsync      <= vsync_in;
        r_s1.is_player  <= w_is_player;
        r_s1.is_goal    <= w_is_goal;
        r_s1.inner      <= w_inner;
      end
      if (w_latch_en) begin
        r_player_col <= player_col;
        r_player_row <= player_row;
        r_goal_col   <= goal_col;
        r_goal_row   <= goal_row;
      end
    end
  end

  // Player beats goal so a shared cell shows the player.
  always_comb begin
    w_rgb = FLOOR;
    if (!r_s1.visible) begin
      w_rgb = BLACK;
    end else if (r_s1.is_player && r_s1.inner) begin
      w_rgb = PLAYER;
    end else if (r_s1.is_goal && r_s1.inner) begin
      w_rgb = GOAL;
    end else if (maze_data) begin
      w_rgb = WALL;
    end else if (game_won && w_blink_phase) begin
      w_rgb = WIN;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rgb       <= BLACK;
      r_hsync_out <= 1'b1;
      r_vsync_out <= 1'b1;
    end else if (pix_en) begin
      r_rgb       <= w_rgb;
      r_hsync_out <= r_s1.hsync;
      r_vsync_out <= r_s1.vsync;
    end
  end

  assign maze_addr = r_maze_addr;
  assign rgb       = r_rgb;
  assign hsync_out = r_hsync_out;
  assign vsync_out = r_vsync_out;

endmodule

// File: tb/tb_maze_pixel_renderer.sv
// Randomized bench for maze_pixel_renderer against a cell-level reference model.
module tb_maze_pixel_renderer;

  localparam int BF = 2;

  logic        clk;
  logic        reset;
  logic        pix_en;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        video_on;
  logic        hsync_in;
  logic        vsync_in;
  logic [10:0] maze_addr;
  logic        maze_data;
  logic [5:0]  player_col;
  logic [4:0]  player_row;
  logic [5:0]  goal_col;
  logic [4:0]  goal_row;
  logic        game_won;
  logic [11:0] rgb;
  logic        hsync_out;
  logic        vsync_out;
  logic        frame_tick;

  maze_pixel_renderer #(.BLINK_FRAMES(BF)) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_en     (pix_en),
    .hcount     (hcount),
    .vcount     (vcount),
    .video_on   (video_on),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .maze_addr  (maze_addr),
    .maze_data  (maze_data),
    .player_col (player_col),
    .player_row (player_row),
    .goal_col   (goal_col),
    .goal_row   (goal_row),
    .game_won   (game_won),
    .rgb        (rgb),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .frame_tick (frame_tick)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- maze RAM model (1-clk read) ----------------
  bit mem [0:2047];
  initial maze_data = 1'b0;
  always @(posedge clk) maze_data <= mem[maze_addr];

  // ---------------- reference model ----------------
  typedef struct {
    int h; int v; bit von; bit hs; bit vs;
    int pc; int pr; int gc; int gr;
  } pix_t;

  pix_t        pend;
  bit          m_prev_vs;
  int          m_won_frames;
  int          m_pc, m_pr, m_gc, m_gr;
  int          m_ticks;
  int          obs_ticks;
  logic [13:0] last_exp;
  int          last_addr;

  logic [13:0] exp_q[$];
  int          n_checks;
  int          n_err;
  logic [11:0] blink_tbl [0:5];

  always @(negedge clk) if (frame_tick === 1'b1) obs_ticks++;

  function automatic int exp_addr(input int h, input int v);
    if (h < 640 && v < 480) return (v / 16) * 40 + h / 16;
    return 0;
  endfunction

  function automatic logic [11:0] exp_colour(input pix_t p, input bit won, input int won_frames);
    int col, row;
    bit inner, phase;
    if (!p.von || p.h >= 640 || p.v >= 480) return 12'h000;
    col   = p.h / 16;
    row   = p.v / 16;
    inner = (p.h % 16 >= 2) && (p.h % 16 <= 13) && (p.v % 16 >= 2) && (p.v % 16 <= 13);
    if (inner && col == p.pc && row == p.pr) return 12'hF80;
    if (inner && col == p.gc && row == p.gr) return 12'h0F0;
    if (mem[row * 40 + col]) return 12'h00F;
    phase = ((won_frames / BF) % 2) == 1;
    if (won && phase) return 12'hFF0;
    return 12'hFFF;
  endfunction

  task automatic model_reset();
    m_prev_vs    = 1'b1;
    m_won_frames = 0;
    m_pc = 0; m_pr = 0; m_gc = 0; m_gr = 0;
    pend.h = 0; pend.v = 0; pend.von = 1'b0; pend.hs = 1'b1; pend.vs = 1'b1;
    pend.pc = 0; pend.pr = 0; pend.gc = 0; pend.gr = 0;
    last_exp  = {1'b1, 1'b1, 12'h000};
    last_addr = 0;
    exp_q.delete();
  endtask

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  // Called #1 after a posedge; leaves the bench #1 after a posedge.
  task automatic send_pix(input int h, input int v, input bit von, input bit hs, input bit vs, input int gap);
    pix_t        np;
    bit          fall;
    logic [13:0] e;
    hcount = 10'(h); vcount = 10'(v); video_on = von; hsync_in = hs; vsync_in = vs;
    pix_en = 1'b1;
    exp_q.push_back({pend.hs, pend.vs, exp_colour(pend, game_won, m_won_frames)});
    np.h = h; np.v = v; np.von = von; np.hs = hs; np.vs = vs;
    np.pc = m_pc; np.pr = m_pr; np.gc = m_gc; np.gr = m_gr;
    fall = m_prev_vs && !vs;
    m_prev_vs = vs;
    @(posedge clk); #1;
    pix_en = 1'b0;
    e = exp_q.pop_front();
    check_eq("rgb", 32'(rgb), 32'(e[11:0]));
    check_eq("hsync_out", 32'(hsync_out), 32'(e[13]));
    check_eq("vsync_out", 32'(vsync_out), 32'(e[12]));
    check_eq("maze_addr", 32'(maze_addr), exp_addr(h, v));
    check_eq("frame_tick", 32'(frame_tick), 32'(fall));
    pend = np;
    if (fall) begin
      m_pc = player_col; m_pr = player_row; m_gc = goal_col; m_gr = goal_row;
      m_ticks++;
    end
    if (!game_won) m_won_frames = 0;
    else if (fall) m_won_frames++;
    last_exp  = e;
    last_addr = exp_addr(h, v);
    for (int i = 0; i < gap; i++) begin
      @(posedge clk); #1;
      if (i == 0) check_eq("tick_width", 32'(frame_tick), 32'd0);
    end
  endtask

  task automatic frame_pulse();
    send_pix(10, 490, 1'b0, 1'b1, 1'b0, 1);
    send_pix(11, 491, 1'b0, 1'b1, 1'b1, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rgb"}, 32'(rgb), 32'h000);
    check_eq({tag, "_hs"}, 32'(hsync_out), 32'd1);
    check_eq({tag, "_vs"}, 32'(vsync_out), 32'd1);
    check_eq({tag, "_addr"}, 32'(maze_addr), 32'd0);
    check_eq({tag, "_tick"}, 32'(frame_tick), 32'd0);
  endtask

  task automatic random_pix();
    int h, v;
    if ($urandom_range(0, 1) == 0) begin
      h = m_pc * 16 + $urandom_range(0, 15);
      v = m_pr * 16 + $urandom_range(0, 15);
    end else begin
      h = $urandom_range(0, 799);
      v = $urandom_range(0, 524);
    end
    send_pix(h, v, $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), 1'b1, $urandom_range(1, 3));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0; n_err = 0; m_ticks = 0; obs_ticks = 0;
    pix_en = 1'b0; hcount = '0; vcount = '0; video_on = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1;
    player_col = '0; player_row = '0; goal_col = '0; goal_row = '0; game_won = 1'b0;
    blink_tbl[0] = 12'hFFF; blink_tbl[1] = 12'hFF0; blink_tbl[2] = 12'hFF0;
    blink_tbl[3] = 12'hFFF; blink_tbl[4] = 12'hFFF; blink_tbl[5] = 12'hFF0;
    for (int i = 0; i < 2048; i++) mem[i] = ($urandom_range(0, 3) == 0);
    mem[122] = 1'b1;
    mem[410] = 1'b0;
    model_reset();

    reset = 1'b1;
    #3 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset = 1'b1;
    @(posedge clk); #1;

    // Wall at cell (2,3) with default shadows at (0,0).
    send_pix(37, 50, 1'b1, 1'b0, 1'b1, 1);
    send_pix(600, 470, 1'b1, 1'b1, 1'b1, 1);
    check_eq("wall_rgb", 32'(rgb), 32'h00F);
    check_eq("wall_hs_delay", 32'(hsync_out), 32'd0);

    // Player on (2,3): inner pixel vs cell-edge pixel, then goal on the same cell.
    player_col = 6'd2; player_row = 5'd3; goal_col = 6'd5; goal_row = 5'd5;
    frame_pulse();
    send_pix(37, 50, 1'b1, 1'b1, 1'b1, 1);
    send_pix(32, 48, 1'b1, 1'b1, 1'b1, 1);
    check_eq("player_rgb", 32'(rgb), 32'hF80);
    send_pix(0, 0, 1'b0, 1'b1, 1'b1, 1);
    check_eq("edge_wall_rgb", 32'(rgb), 32'h00F);
    goal_col = 6'd2; goal_row = 5'd3;
    frame_pulse();
    send_pix(37, 50, 1'b1, 1'b1, 1'b1, 1);
    send_pix(0, 0, 1'b0, 1'b1, 1'b1, 1);
    check_eq("player_over_goal", 32'(rgb), 32'hF80);

    // Mid-frame player move only takes effect at the next frame start.
    player_col = 6'd10;
    send_pix(37, 50, 1'b1, 1'b1, 1'b1, 2);
    send_pix(0, 0, 1'b0, 1'b1, 1'b1, 1);
    check_eq("no_tearing", 32'(rgb), 32'hF80);
    frame_pulse();
    send_pix(37, 50, 1'b1, 1'b1, 1'b1, 1);
    send_pix(0, 0, 1'b0, 1'b1, 1'b1, 1);
    check_eq("moved_goal_shows", 32'(rgb), 32'h0F0);

    // Win flash on a floor cell (10,10).
    player_col = 6'd30; player_row = 5'd25; goal_col = 6'd20; goal_row = 5'd20;
    game_won = 1'b1;
    for (int k = 0; k < 6; k++) begin
      frame_pulse();
      send_pix(168, 168, 1'b1, 1'b1, 1'b1, 1);
      send_pix(0, 0, 1'b0, 1'b1, 1'b1, 1);
      check_eq("blink_seq", 32'(rgb), 32'(blink_tbl[k]));
    end
    game_won = 1'b0;
    send_pix(168, 168, 1'b1, 1'b1, 1'b1, 1);
    send_pix(0, 0, 1'b0, 1'b1, 1'b1, 1);
    check_eq("won_cleared", 32'(rgb), 32'hFFF);
    game_won = 1'b1;
    frame_pulse();
    send_pix(168, 168, 1'b1, 1'b1, 1'b1, 1);
    send_pix(0, 0, 1'b0, 1'b1, 1'b1, 1);
    check_eq("count_restart", 32'(rgb), 32'hFFF);
    game_won = 1'b0;

    // Out-of-range column, then pix_en held low.
    send_pix(700, 100, 1'b1, 1'b0, 1'b1, 1);
    send_pix(300, 200, 1'b1, 1'b1, 1'b1, 1);
    check_eq("oor_rgb", 32'(rgb), 32'h000);
    for (int i = 0; i < 10; i++) begin
      hcount = 10'($urandom_range(0, 639)); vcount = 10'($urandom_range(0, 479));
      video_on = 1'b1; hsync_in = 1'($urandom_range(0, 1)); vsync_in = 1'b0;
      @(posedge clk); #1;
    end
    check_eq("hold_rgb", 32'(rgb), 32'(last_exp[11:0]));
    check_eq("hold_hs", 32'(hsync_out), 32'(last_exp[13]));
    check_eq("hold_vs", 32'(vsync_out), 32'(last_exp[12]));
    check_eq("hold_addr", 32'(maze_addr), last_addr);
    check_eq("hold_tick", 32'(frame_tick), 32'd0);
    vsync_in = 1'b1;

    // Reset in the middle of a line while pix_en keeps toggling.
    send_pix(37, 50, 1'b1, 1'b0, 1'b1, 1);
    send_pix(40, 60, 1'b1, 1'b0, 1'b1, 1);
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      pix_en = ~pix_en;
    end
    pix_en = 1'b0;
    check_reset_outputs("rst_held");
    model_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    send_pix(37, 50, 1'b1, 1'b0, 1'b1, 1);
    send_pix(100, 100, 1'b1, 1'b1, 1'b1, 1);
    check_eq("post_rst_rgb", 32'(rgb), 32'h00F);

    // Randomized frames.
    for (int f = 0; f < 10; f++) begin
      game_won   = 1'($urandom_range(0, 1));
      player_col = 6'($urandom_range(0, 39)); player_row = 5'($urandom_range(0, 29));
      goal_col   = 6'($urandom_range(0, 39)); goal_row   = 5'($urandom_range(0, 29));
      frame_pulse();
      for (int p = 0; p < 40; p++) begin
        if ($urandom_range(0, 9) == 0) begin
          player_col = 6'($urandom_range(0, 39)); player_row = 5'($urandom_range(0, 29));
        end
        random_pix();
      end
    end

    check_eq("tick_count", obs_ticks, m_ticks);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
